fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 50 +++++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: machine word, boot vector and the two queue payload types.
// Also used by builds with FETCH_MISALIGN_CHECK_EN defined.
package fetch_unit_pkg;

    typedef logic [31:0] word;

    localparam word         BOOT_ADDRESS = 32'h0000_0000;
    localparam int unsigned QueueDepth   = 2;

    typedef struct packed {
        word instr;
        word pc;
        word pc_plus4;
    } fetch_entry_t;

    typedef struct packed {
        word  pc;
        word  pc_plus4;
        logic epoch;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: PC side, instruction-memory request/response and decode handshake.
// dec_misaligned exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    word  pc_addr;
    word  pc_plus4;
    logic flush;
    logic pc_stall;

    logic imem_req_valid;
    logic imem_req_ready;
    word  imem_req_addr;
    logic imem_resp_valid;
    word  imem_resp_data;

    logic dec_valid;
    logic dec_ready;
    word  dec_instr;
    word  dec_pc;
    word  dec_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic dec_misaligned;
`endif

    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output dec_misaligned,
`endif
        input  pc_addr, pc_plus4, flush,
        output pc_stall,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        input  dec_ready
    );

    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  dec_misaligned,
`endif
        output pc_addr, pc_plus4, flush,
        input  pc_stall,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        output dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; a clear in the same cycle as a push leaves only the new entry.
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic [31:0]
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output T                             data_o,
    output logic [$clog2(Depth + 1)-1:0] count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else if (pop_i && (cnt_q != '0)) begin
            rd_d  = ptr_inc(rd_q);
            cnt_d = cnt_q - CntW'(1);
        end
        if (push_i) begin
            mem_d[wr_d] = data_i;
            wr_d        = ptr_inc(wr_d);
            cnt_d       = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch with epoch-tagged in-flight requests and a 2-entry output FIFO.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned PCs bypass memory and are flagged on dec_misaligned.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input logic          clock,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    logic            epoch_q, epoch_d;
    logic [CntW-1:0] inflight, fcount, fcount_eff;
    logic            credit_ok, misalign, mem_accept, mis_accept;
    logic            resp_fire, keep_resp, out_push, out_pop, out_valid;
    fetch_tag_t      tag_in, tag_head;
    fetch_entry_t    entry_in, entry_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = |bus.pc_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        // A flush empties the FIFO this cycle, so the credit check already sees it empty.
        fcount_eff = bus.flush ? '0 : fcount;
        credit_ok  = !reset && (({1'b0, inflight} + {1'b0, fcount_eff}) < (CntW + 1)'(2));
        mem_accept = credit_ok && !misalign && bus.imem_req_ready;
        // Bypass only with nothing in flight so older responses stay ahead in the FIFO.
        mis_accept = credit_ok && misalign && (inflight == '0);

        epoch_d   = bus.flush ? !epoch_q : epoch_q;
        resp_fire = bus.imem_resp_valid && (inflight != '0);
        keep_resp = resp_fire && (tag_head.epoch == epoch_d);

        tag_in.pc       = bus.pc_addr;
        tag_in.pc_plus4 = bus.pc_plus4;
        tag_in.epoch    = epoch_d;

        out_push          = keep_resp || mis_accept;
        entry_in.instr    = mis_accept ? '0 : bus.imem_resp_data;
        entry_in.pc       = mis_accept ? bus.pc_addr : tag_head.pc;
        entry_in.pc_plus4 = mis_accept ? bus.pc_plus4 : tag_head.pc_plus4;

        out_valid = !reset && (fcount != '0);
        out_pop   = out_valid && bus.dec_ready && !bus.flush;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            epoch_q <= 1'b0;
        end else begin
            epoch_q <= epoch_d;
        end
    end

    fetch_fifo #(
        .Depth (QueueDepth),
        .T     (fetch_tag_t)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (mem_accept),
        .data_i  (tag_in),
        .pop_i   (resp_fire),
        .clear_i (1'b0),
        .data_o  (tag_head),
        .count_o (inflight)
    );

    fetch_fifo #(
        .Depth (QueueDepth),
        .T     (fetch_entry_t)
    ) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (out_push),
        .data_i  (entry_in),
        .pop_i   (out_pop),
        .clear_i (bus.flush),
        .data_o  (entry_head),
        .count_o (fcount)
    );

    assign bus.imem_req_valid = credit_ok && !misalign;
    assign bus.imem_req_addr  = bus.pc_addr;
    assign bus.pc_stall       = !(mem_accept || mis_accept);
    assign bus.dec_valid      = out_valid;
    assign bus.dec_instr      = out_valid ? entry_head.instr : '0;
    assign bus.dec_pc         = out_valid ? entry_head.pc : '0;
    assign bus.dec_pc_plus4   = out_valid ? entry_head.pc_plus4 : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.dec_misaligned = out_valid && (entry_head.pc[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC model, queued instruction memory (data = addr ^ CAFE0000).
// The misaligned-PC case runs only when FETCH_MISALIGN_CHECK_EN is defined.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam word Magic = 32'hCAFE_0000;

    logic clock = 1'b0;
    logic reset;
    fetch_unit_if bus ();

    fetch_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    word  pc_q, flush_target, mq0, mq1;
    int   mcnt;
    logic mem_hold, spur, mem_pop, mem_push;
    word  req_log[$];
    word  dec_pc_log[$];
    word  dec_instr_log[$];
    word  dec_p4_log[$];
    int   checks = 0;
    int   errors = 0;

    assign bus.pc_addr         = bus.flush ? flush_target : pc_q;
    assign bus.pc_plus4        = bus.pc_addr + 32'd4;
    assign bus.imem_resp_valid = ((mcnt != 0) && !mem_hold) || spur;
    assign bus.imem_resp_data  = mq0 ^ Magic;
    assign mem_pop             = bus.imem_resp_valid && (mcnt != 0);
    assign mem_push            = bus.imem_req_valid && bus.imem_req_ready;

    always @(posedge clock) begin
        if (reset) pc_q <= BOOT_ADDRESS;
        else if (!bus.pc_stall) pc_q <= bus.pc_plus4;
        else if (bus.flush) pc_q <= flush_target;
    end

    always @(posedge clock) begin
        if (reset) begin
            mcnt <= 0;
        end else if (mem_pop && mem_push) begin
            if (mcnt == 1) mq0 <= bus.imem_req_addr;
            else begin
                mq0 <= mq1;
                mq1 <= bus.imem_req_addr;
            end
        end else if (mem_pop) begin
            mq0  <= mq1;
            mcnt <= mcnt - 1;
        end else if (mem_push) begin
            if (mcnt == 0) mq0 <= bus.imem_req_addr;
            else mq1 <= bus.imem_req_addr;
            mcnt <= mcnt + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.imem_req_valid && bus.imem_req_ready) req_log.push_back(bus.imem_req_addr);
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                dec_pc_log.push_back(bus.dec_pc);
                dec_instr_log.push_back(bus.dec_instr);
                dec_p4_log.push_back(bus.dec_pc_plus4);
            end
        end
    end

    task automatic check_eq(input string tag, input word got, input word exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word pick(input word q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic adv(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start(input logic rr, input logic dr);
        reset                = 1'b1;
        bus.flush            = 1'b0;
        bus.imem_req_ready   = rr;
        bus.dec_ready        = dr;
        mem_hold             = 1'b0;
        spur                 = 1'b0;
        flush_target         = '0;
        adv(2);
        reset = 1'b0;
        req_log.delete();
        dec_pc_log.delete();
        dec_instr_log.delete();
        dec_p4_log.delete();
    endtask

    initial begin
        // Reset values
        reset = 1'b1; bus.flush = 1'b0; bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1;
        mem_hold = 1'b0; spur = 1'b0; flush_target = '0;
        adv(1);
        @(negedge clock);
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_pc_stall", 32'(bus.pc_stall), 32'd1);
        check_eq("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check_eq("rst_dec_instr", bus.dec_instr, 32'd0);
        check_eq("rst_dec_pc", bus.dec_pc, 32'd0);
        check_eq("rst_dec_pc_plus4", bus.dec_pc_plus4, 32'd0);

        // Streaming from boot
        start(1'b1, 1'b1);
        @(negedge clock);
        check_eq("boot_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("boot_req_addr", bus.imem_req_addr, BOOT_ADDRESS);
        check_eq("boot_pc_stall", 32'(bus.pc_stall), 32'd0);
        adv(9);
        check_eq("seq_req0", pick(req_log, 0), 32'h0);
        check_eq("seq_req1", pick(req_log, 1), 32'h4);
        check_eq("seq_req2", pick(req_log, 2), 32'h8);
        check_eq("seq_dec_pc0", pick(dec_pc_log, 0), 32'h0);
        check_eq("seq_dec_pc1", pick(dec_pc_log, 1), 32'h4);
        check_eq("seq_dec_pc2", pick(dec_pc_log, 2), 32'h8);
        check_eq("seq_dec_instr0", pick(dec_instr_log, 0), 32'hCAFE_0000);
        check_eq("seq_dec_instr2", pick(dec_instr_log, 2), 32'hCAFE_0008);
        check_eq("seq_dec_p4_1", pick(dec_p4_log, 1), 32'h8);

        // Decode backpressure: credits cap outstanding work at two
        start(1'b1, 1'b0);
        adv(9);
        @(negedge clock);
        check_eq("bp_req_count", 32'(req_log.size()), 32'd2);
        check_eq("bp_pc_stall", 32'(bus.pc_stall), 32'd1);
        check_eq("bp_pc_held", bus.pc_addr, 32'h8);
        check_eq("bp_dec_valid", 32'(bus.dec_valid), 32'd1);
        check_eq("bp_dec_pc", bus.dec_pc, 32'h0);
        adv(1);
        bus.dec_ready = 1'b1;
        adv(8);
        check_eq("bp_rel_pc0", pick(dec_pc_log, 0), 32'h0);
        check_eq("bp_rel_pc1", pick(dec_pc_log, 1), 32'h4);
        check_eq("bp_rel_pc2", pick(dec_pc_log, 2), 32'h8);
        check_eq("bp_rel_instr1", pick(dec_instr_log, 1), 32'hCAFE_0004);

        // Flush with two requests in flight; stale responses must be dropped
        start(1'b1, 1'b1);
        mem_hold = 1'b1;
        adv(2);
        @(negedge clock);
        check_eq("fl_full_stall", 32'(bus.pc_stall), 32'd1);
        adv(1);
        bus.flush = 1'b1; flush_target = 32'h100; mem_hold = 1'b0;
        @(negedge clock);
        check_eq("fl_no_credit", 32'(bus.imem_req_valid), 32'd0);
        adv(1);
        bus.flush = 1'b0;
        adv(8);
        check_eq("fl_req2", pick(req_log, 2), 32'h100);
        check_eq("fl_dec_pc0", pick(dec_pc_log, 0), 32'h100);
        check_eq("fl_dec_instr0", pick(dec_instr_log, 0), 32'hCAFE_0100);
        check_eq("fl_dec_pc1", pick(dec_pc_log, 1), 32'h104);

        // Memory not ready: PC held, nothing tagged
        start(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("nr_pc_stall", 32'(bus.pc_stall), 32'd1);
            check_eq("nr_pc_held", bus.imem_req_addr, 32'h0);
            adv(1);
        end
        check_eq("nr_req_count", 32'(req_log.size()), 32'd0);
        bus.imem_req_ready = 1'b1;
        adv(8);
        check_eq("nr_dec_pc0", pick(dec_pc_log, 0), 32'h0);
        check_eq("nr_dec_pc1", pick(dec_pc_log, 1), 32'h4);
        check_eq("nr_dec_instr1", pick(dec_instr_log, 1), 32'hCAFE_0004);

        // Flush together with a decode pop and a stale response
        start(1'b1, 1'b0);
        adv(2);
        mem_hold = 1'b1;
        adv(1);
        bus.flush = 1'b1; flush_target = 32'h200; bus.dec_ready = 1'b1; mem_hold = 1'b0;
        @(negedge clock);
        check_eq("fp_dec_valid", 32'(bus.dec_valid), 32'd1);
        check_eq("fp_resp_valid", 32'(bus.imem_resp_valid), 32'd1);
        check_eq("fp_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("fp_req_addr", bus.imem_req_addr, 32'h200);
        adv(1);
        bus.flush = 1'b0;
        @(negedge clock);
        check_eq("fp_empty", 32'(bus.dec_valid), 32'd0);
        adv(6);
        check_eq("fp_req2", pick(req_log, 2), 32'h200);
        check_eq("fp_dec_pc0", pick(dec_pc_log, 0), 32'h200);
        check_eq("fp_dec_instr0", pick(dec_instr_log, 0), 32'hCAFE_0200);

        // Response with nothing in flight is ignored
        start(1'b0, 1'b1);
        spur = 1'b1;
        adv(1);
        spur = 1'b0;
        @(negedge clock);
        check_eq("sp_dec_valid", 32'(bus.dec_valid), 32'd0);
        check_eq("sp_req_valid", 32'(bus.imem_req_valid), 32'd1);
        adv(1);
        bus.imem_req_ready = 1'b1;
        adv(6);
        check_eq("sp_dec_pc0", pick(dec_pc_log, 0), 32'h0);
        check_eq("sp_dec_instr0", pick(dec_instr_log, 0), 32'hCAFE_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned target bypasses memory
        start(1'b1, 1'b0);
        bus.flush = 1'b1; flush_target = 32'h102;
        @(negedge clock);
        check_eq("ma_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("ma_pc_stall", 32'(bus.pc_stall), 32'd0);
        adv(1);
        bus.flush = 1'b0;
        @(negedge clock);
        check_eq("ma_flag", 32'(bus.dec_misaligned), 32'd1);
        check_eq("ma_dec_pc", bus.dec_pc, 32'h102);
        check_eq("ma_dec_instr", bus.dec_instr, 32'h0);
        check_eq("ma_req_count", 32'(req_log.size()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
